mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive denied fetch cycles before fetch gets forced priority (range 1-15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch read request, held until if_gnt.
REQ-005 if_addr  input  32  fetch byte address, word aligned.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 dm_req  input  1  data-memory request, held until dm_gnt.
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_addr  input  32  data byte address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_be  input  4  store byte enables.
REQ-014 dm_gnt  output  1  data request accepted this cycle.
REQ-015 dm_rvalid  output  1  dm_rdata valid (loads only).
REQ-016 dm_rdata  output  32  load data.
REQ-017 mem_ce  output  1  memory access issued this cycle.
REQ-018 mem_we, mem_be, mem_addr, mem_wdata  output  1/4/32/32  access controls, valid when mem_ce=1.
REQ-019 mem_ready  input  1  memory can accept an access this cycle.
REQ-020 mem_rdata  input  32  read data, valid exactly one cycle after an accepted read.

Function
REQ-021 Block SHALL share one single-ported memory between fetch and data requesters, issuing at most one access per cycle.
REQ-022 Access issues (mem_ce=1) only when mem_ready=1 and at least one request is pending; grant is combinational in that same cycle.
REQ-023 Default priority: data over fetch (dm_req wins when both pending).
REQ-024 Exactly one of if_gnt/dm_gnt SHALL be 1 whenever mem_ce=1; both 0 otherwise.
REQ-025 mem_addr/mem_we/mem_be/mem_wdata SHALL mux from the granted requester; for fetch mem_we=0, mem_be=4'hF.
REQ-026 Read latency: rvalid asserted on owner port exactly one cycle after grant, for one cycle, rdata = mem_rdata; stores produce no rvalid.
REQ-027 Owner of the in-flight read SHALL be held in a registered tag (states IDLE, RD_IF, RD_DM); new grants are allowed in the rvalid cycle (back-to-back, one access per cycle sustained).
REQ-028 Stall: mem_ready=0 SHALL block all grants; pending requests and starvation count hold, rvalid for an already accepted read still returns.
REQ-029 rdata outputs SHALL be 0 when corresponding rvalid=0.

Reset
REQ-030 While reset=0: if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_ce = 0; state = IDLE; starvation counter = 0.
REQ-031 Reset asserted with a read in flight SHALL discard it; no rvalid after reset release.
REQ-032 First grant possible in the first cycle after reset deasserts.

Configuration
REQ-033 Macro MEM_PORT_ARBITER_FAIRNESS_EN SHALL control the fetch starvation guard.
REQ-034 Defined: 4-bit counter increments each cycle if_req=1, dm wins, and mem_ready=1; on reaching STARVE_LIMIT fetch wins the next contended grant; counter clears on any if_gnt.
REQ-035 Undefined: no counter, strict data priority; fetch may starve indefinitely.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0x10, mem_ready=1, mem_rdata=0x00500093 next cycle -> if_gnt same cycle, if_rvalid=1 with if_rdata=0x00500093 one cycle later.
REQ-037 Contention: if_req=dm_req=1 (load 0x100) -> dm_gnt first, mem_addr=0x100; if_gnt next cycle; dm_rvalid and if_rvalid in consecutive cycles.
REQ-038 Store: dm_req=1, dm_we=1, dm_be=4'b0011, dm_wdata=0xDEADBEEF -> mem_ce=1, mem_we=1, mem_be=4'b0011; no dm_rvalid.
REQ-039 Starvation (fairness on, STARVE_LIMIT=4): dm_req and if_req held 1 -> 4 dm grants, then if_gnt on 5th access; fairness off -> no if_gnt for 20 cycles.
REQ-040 Stall/reset: mem_ready=0 for 3 cycles with both requests -> no grants, no mem_ce; reset=0 one cycle after a fetch grant -> no if_rvalid, all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared single-ported memory.
// The slave modport is the arbiter's view; the master modport is the requesters and memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_ce, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_ce, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, data first.
// Define MEM_PORT_ARBITER_FAIRNESS_EN to add the fetch starvation guard (STARVE_LIMIT).
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_DM = 2'd2
  } rd_state_e;

  rd_state_e r_state;
  rd_state_e w_state_nxt;
  logic      w_issue;
  logic      w_if_win;
  logic      w_fetch_first;
  logic      w_if_gnt;
  logic      w_dm_gnt;
  logic      w_if_rvalid;
  logic      w_dm_rvalid;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
  end

`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  assign w_fetch_first = bus.if_req & (r_starve_cnt >= LIMIT);

  // Counts accesses lost by a waiting fetch; any fetch grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_if_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_dm_gnt && bus.if_req && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_fetch_first = 1'b0;
`endif

  // Reset gates the grant path so no access leaks out while rst_n is low.
  assign w_issue  = rst_n & bus.mem_ready & (bus.if_req | bus.dm_req);
  assign w_if_win = bus.if_req & (~bus.dm_req | w_fetch_first);
  assign w_if_gnt = w_issue & w_if_win;
  assign w_dm_gnt = w_issue & ~w_if_win;

  assign bus.if_gnt = w_if_gnt;
  assign bus.dm_gnt = w_dm_gnt;
  assign bus.mem_ce = w_issue;

  // Memory access controls follow the granted requester.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    if (w_if_gnt) begin
      bus.mem_we   = 1'b0;
      bus.mem_be   = 4'hF;
      bus.mem_addr = bus.if_addr;
    end else if (w_dm_gnt) begin
      bus.mem_we    = bus.dm_we;
      bus.mem_be    = bus.dm_be;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
    end else begin
      bus.mem_we    = 1'b0;
    end
  end

  // Read-owner tag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next owner comes from this cycle's grant; rvalid decodes the owner of last cycle's read.
  always_comb begin
    w_state_nxt = IDLE;
    w_if_rvalid = 1'b0;
    w_dm_rvalid = 1'b0;
    if (w_if_gnt) begin
      w_state_nxt = RD_IF;
    end else if (w_dm_gnt && !bus.dm_we) begin
      w_state_nxt = RD_DM;
    end else begin
      w_state_nxt = IDLE;
    end
    case (r_state)
      RD_IF:   w_if_rvalid = 1'b1;
      RD_DM:   w_dm_rvalid = 1'b1;
      default: begin
        w_if_rvalid = 1'b0;
        w_dm_rvalid = 1'b0;
      end
    endcase
  end

  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dm_rvalid = w_dm_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.dm_rdata  = w_dm_rvalid ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a requester/memory model predicts each access and read return.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct {
    int          cyc;
    bit          dm;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    int          cyc;
    bit          dm;
    logic [31:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  acc_t gq[$];
  rd_t  rq[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  bit          if_pend = 1'b0;
  logic [31:0] if_a    = 32'h0;
  bit          dm_pend = 1'b0;
  bit          dm_w    = 1'b0;
  logic [31:0] dm_a    = 32'h0;
  logic [31:0] dm_d    = 32'h0;
  logic [3:0]  dm_b    = 4'h0;
  bit          have_rd = 1'b0;
  logic [31:0] rd_val  = 32'h0;
  int          starve  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  task automatic apply_reqs();
    bus.if_req   = if_pend;
    bus.if_addr  = if_a;
    bus.dm_req   = dm_pend;
    bus.dm_we    = dm_w;
    bus.dm_addr  = dm_a;
    bus.dm_wdata = dm_d;
    bus.dm_be    = dm_b;
  endtask

  task automatic raise_if(input logic [31:0] addr);
    if_pend = 1'b1;
    if_a    = {addr[31:2], 2'b00};
  endtask

  task automatic raise_dm(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    dm_pend = 1'b1;
    dm_w    = we;
    dm_a    = addr;
    dm_d    = wd;
    dm_b    = be;
  endtask

  // One clock of stimulus; the model decides who should win from the arbitration rules.
  task automatic drive_cycle(input bit rdy, input logic [31:0] pick);
    acc_t a;
    rd_t  r;
    bit   dm_wins;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    apply_reqs();
    bus.mem_ready = rdy;
    bus.mem_rdata = have_rd ? rd_val : $urandom();
    have_rd = 1'b0;
    if (rdy && (if_pend || dm_pend)) begin
      dm_wins = dm_pend && !(FAIR && if_pend && (starve >= LIMIT));
      a.cyc = cyc;
      if (dm_wins) begin
        a.dm = 1'b1; a.we = dm_w; a.be = dm_b; a.addr = dm_a; a.wdata = dm_d;
        if (if_pend && (starve < 15)) starve++;
        dm_pend = 1'b0;
      end else begin
        a.dm = 1'b0; a.we = 1'b0; a.be = 4'hF; a.addr = if_a; a.wdata = 32'h0;
        starve  = 0;
        if_pend = 1'b0;
      end
      gq.push_back(a);
      if (!a.we) begin
        have_rd = 1'b1;
        rd_val  = pick;
        r.cyc = cyc + 1; r.dm = a.dm; r.data = pick;
        rq.push_back(r);
      end
    end
  endtask

  // Reset discards anything in flight, so expectations are dropped too.
  task automatic reset_cycle();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b0;
    apply_reqs();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = $urandom();
    have_rd = 1'b0;
    starve  = 0;
    gq.delete();
    rq.delete();
  endtask

  always @(negedge clk) begin : monitor
    acc_t e;
    rd_t  r;
    if (rst_n !== 1'b1) begin
      check("reset_outputs", 64'({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_ce}), 64'(0));
    end else begin
      while ((gq.size() > 0) && (gq[0].cyc < cyc)) begin
        check("missed_access_cycle", 64'(cyc), 64'(gq[0].cyc));
        void'(gq.pop_front());
      end
      while ((rq.size() > 0) && (rq[0].cyc < cyc)) begin
        check("missed_rvalid_cycle", 64'(cyc), 64'(rq[0].cyc));
        void'(rq.pop_front());
      end
      if (bus.mem_ce === 1'b1) begin
        if (gq.size() == 0) begin
          check("unexpected_access", 64'(bus.mem_ce), 64'(0));
        end else begin
          e = gq.pop_front();
          check("access_cycle", 64'(cyc), 64'(e.cyc));
          check("grant_owner", 64'({bus.if_gnt, bus.dm_gnt}), e.dm ? 64'(2'b01) : 64'(2'b10));
          check("mem_we", 64'(bus.mem_we), 64'(e.we));
          check("mem_be", 64'(bus.mem_be), 64'(e.be));
          check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
          if (e.we) check("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
        end
      end else begin
        check("idle_no_grant", 64'({bus.if_gnt, bus.dm_gnt}), 64'(0));
      end
      if ((bus.if_rvalid === 1'b1) || (bus.dm_rvalid === 1'b1)) begin
        if (rq.size() == 0) begin
          check("unexpected_rvalid", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'(0));
        end else begin
          r = rq.pop_front();
          check("rvalid_cycle", 64'(cyc), 64'(r.cyc));
          check("rvalid_owner", 64'({bus.if_rvalid, bus.dm_rvalid}), r.dm ? 64'(2'b01) : 64'(2'b10));
          check("rdata", r.dm ? 64'(bus.dm_rdata) : 64'(bus.if_rdata), 64'(r.data));
        end
      end
    end
    if (bus.if_rvalid !== 1'b1) check("if_rdata_zero", 64'(bus.if_rdata), 64'(0));
    if (bus.dm_rvalid !== 1'b1) check("dm_rdata_zero", 64'(bus.dm_rdata), 64'(0));
  end

  initial begin
    logic [31:0] t;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    raise_if(32'h0000_0010);
    apply_reqs();
    repeat (3) reset_cycle();

    // Fetch only, first cycle after reset release.
    drive_cycle(1'b1, 32'h0050_0093);
    drive_cycle(1'b1, $urandom());

    // Contention: data load wins, fetch follows.
    raise_if(32'h0000_0020);
    raise_dm(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    drive_cycle(1'b1, 32'h1111_1111);
    drive_cycle(1'b1, 32'h2222_2222);
    drive_cycle(1'b1, $urandom());

    // Store produces no read return.
    raise_dm(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
    drive_cycle(1'b1, $urandom());
    drive_cycle(1'b1, $urandom());

    // Stall with both pending, then release.
    raise_if(32'h0000_0030);
    raise_dm(1'b0, 32'h0000_0300, 32'h0, 4'hF);
    repeat (3) drive_cycle(1'b0, $urandom());
    repeat (3) drive_cycle(1'b1, $urandom());

    // Sustained data pressure against a waiting fetch.
    raise_if(32'h0000_0040);
    for (int i = 0; i < 24; i++) begin
      if (!dm_pend) raise_dm(1'b0, 32'h0000_0400 + 32'(i * 4), 32'h0, 4'hF);
      drive_cycle(1'b1, $urandom());
    end
    for (int i = 0; i < 30 && (if_pend || dm_pend); i++) drive_cycle(1'b1, $urandom());
    drive_cycle(1'b1, $urandom());

    // Reset one cycle after a fetch grant.
    raise_if(32'h0000_0050);
    drive_cycle(1'b1, $urandom());
    reset_cycle();
    drive_cycle(1'b1, $urandom());
    drive_cycle(1'b1, $urandom());

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (!if_pend && ($urandom_range(0, 2) != 0)) begin
        t = $urandom();
        raise_if(t);
      end
      if (!dm_pend && ($urandom_range(0, 2) != 0)) begin
        t = $urandom();
        raise_dm(1'($urandom_range(0, 1)), t, $urandom(), 4'($urandom_range(0, 15)));
      end
      drive_cycle($urandom_range(0, 3) != 0, $urandom());
    end
    for (int i = 0; i < 40 && (if_pend || dm_pend); i++) drive_cycle(1'b1, $urandom());
    repeat (3) drive_cycle(1'b1, $urandom());

    check("access_queue_drained", 64'(gq.size()), 64'(0));
    check("read_queue_drained", 64'(rq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
